// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multicycle MIPS control unit: phase one-hots,
// opcodes, ALU/PC-select codes and the decoded control word.
package mips_ctrl_pkg;

  localparam int unsigned STATE_W   = 6;
  localparam int unsigned OP_W      = 6;
  localparam int unsigned RETIRED_W = 32;

  // The execute stage compares against this same constant.
  localparam logic [STATE_W-1:0] EX = 6'b000100;

  typedef enum logic [STATE_W-1:0] {
    S_IF   = 6'b000001,
    S_ID   = 6'b000010,
    S_EX   = EX,
    S_MEM  = 6'b001000,
    S_WB   = 6'b010000,
    S_HALT = 6'b100000
  } state_t;

  localparam logic [OP_W-1:0] OP_R    = 6'b000000;
  localparam logic [OP_W-1:0] OP_LW   = 6'b100011;
  localparam logic [OP_W-1:0] OP_SW   = 6'b101011;
  localparam logic [OP_W-1:0] OP_BEQ  = 6'b000100;
  localparam logic [OP_W-1:0] OP_ADDI = 6'b001000;
  localparam logic [OP_W-1:0] OP_J    = 6'b000010;
  localparam logic [OP_W-1:0] OP_HALT = 6'b111111;

  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_RTYPE = 2'b10;

  localparam logic [1:0] PC_SEQ    = 2'b00;
  localparam logic [1:0] PC_BRANCH = 2'b01;
  localparam logic [1:0] PC_JUMP   = 2'b10;

  typedef struct packed {
    logic [1:0] alu_op;
    logic       alu_src;
    logic       reg_dst;
    logic       reg_write;
    logic       mem_to_reg;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       pc_write;
    logic [1:0] pc_src;
    logic       illegal;
  } ctrl_t;

  function automatic logic is_legal(input logic [OP_W-1:0] op);
    case (op)
      OP_R, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J, OP_HALT: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/ctrl_decode.sv
// Combinational strobe decoder: phase and latched opcode to datapath controls.
// ID looks at the live opcode because op_q is only loaded when ID ends.
module ctrl_decode
  import mips_ctrl_pkg::*;
(
  input  state_t          state_q,
  input  logic [OP_W-1:0] op_q,
  input  logic [OP_W-1:0] opcode,
  input  logic            zero,
  input  logic            mem_ready,
  output ctrl_t           ctrl
);

  always_comb begin
    ctrl = '0;

    // ALU setup is established in EX and held until the instruction ends.
    if (state_q inside {S_EX, S_MEM, S_WB}) begin
      case (op_q)
        OP_R: ctrl.alu_op = ALU_RTYPE;
        OP_LW, OP_SW, OP_ADDI: begin
          ctrl.alu_op  = ALU_ADD;
          ctrl.alu_src = 1'b1;
        end
        OP_BEQ: ctrl.alu_op = ALU_SUB;
        default: ;
      endcase
    end

    case (state_q)
      S_IF: begin
        ctrl.mem_read = 1'b1;
        if (mem_ready) begin
          ctrl.ir_write = 1'b1;
          ctrl.pc_write = 1'b1;
          ctrl.pc_src   = PC_SEQ;
        end
      end
      S_ID: begin
        ctrl.illegal = ~is_legal(opcode);
        if (opcode == OP_J) begin
          ctrl.pc_write = 1'b1;
          ctrl.pc_src   = PC_JUMP;
        end
      end
      S_EX: begin
        if (op_q == OP_BEQ) begin
          ctrl.pc_write = zero;
          ctrl.pc_src   = PC_BRANCH;
        end
      end
      S_MEM: begin
        ctrl.mem_read  = (op_q == OP_LW);
        ctrl.mem_write = (op_q == OP_SW);
      end
      S_WB: begin
        ctrl.reg_write  = 1'b1;
        ctrl.reg_dst    = (op_q == OP_R);
        ctrl.mem_to_reg = (op_q == OP_LW);
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mc_control_fsm.sv
// Multicycle MIPS main control: phase register, latched opcode and retired
// instruction counter, with strobes decoded by ctrl_decode.
module mc_control_fsm
  import mips_ctrl_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset,
  input  logic [OP_W-1:0]      opcode,
  input  logic                 zero,
  input  logic                 mem_ready,
  output logic [STATE_W-1:0]   state,
  output logic [1:0]           ALUop,
  output logic                 ALUSrc,
  output logic                 RegDst,
  output logic                 RegWrite,
  output logic                 MemtoReg,
  output logic                 MemRead,
  output logic                 MemWrite,
  output logic                 IRWrite,
  output logic                 PCWrite,
  output logic [1:0]           PCSrc,
  output logic                 illegal,
  output logic [RETIRED_W-1:0] retired
);

  state_t          state_q;
  logic [OP_W-1:0] op_q;
  ctrl_t           dec;
  ctrl_t           ctrl;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IF;
      op_q    <= '0;
      retired <= '0;
    end else begin
      case (state_q)
        S_IF: if (mem_ready) state_q <= S_ID;
        S_ID: begin
          op_q <= opcode;
          case (opcode)
            OP_R, OP_LW, OP_SW, OP_BEQ, OP_ADDI: state_q <= S_EX;
            OP_J: begin
              state_q <= S_IF;
              retired <= retired + RETIRED_W'(1);
            end
            OP_HALT: state_q <= S_HALT;
            default: state_q <= S_IF;
          endcase
        end
        S_EX: begin
          case (op_q)
            OP_R, OP_ADDI: state_q <= S_WB;
            OP_LW, OP_SW:  state_q <= S_MEM;
            OP_BEQ: begin
              state_q <= S_IF;
              retired <= retired + RETIRED_W'(1);
            end
            default: state_q <= S_IF;
          endcase
        end
        S_MEM: begin
          if (mem_ready) begin
            if (op_q == OP_LW) begin
              state_q <= S_WB;
            end else begin
              state_q <= S_IF;
              retired <= retired + RETIRED_W'(1);
            end
          end
        end
        S_WB: begin
          state_q <= S_IF;
          retired <= retired + RETIRED_W'(1);
        end
        S_HALT: state_q <= S_HALT;
        default: state_q <= S_IF;
      endcase
    end
  end

  ctrl_decode u_decode (
    .state_q   (state_q),
    .op_q      (op_q),
    .opcode    (opcode),
    .zero      (zero),
    .mem_ready (mem_ready),
    .ctrl      (dec)
  );

  // Strobes are forced quiet while reset is held so no write can slip out.
  always_comb begin
    ctrl = reset ? '0 : dec;
  end

  assign state    = state_q;
  assign ALUop    = ctrl.alu_op;
  assign ALUSrc   = ctrl.alu_src;
  assign RegDst   = ctrl.reg_dst;
  assign RegWrite = ctrl.reg_write;
  assign MemtoReg = ctrl.mem_to_reg;
  assign MemRead  = ctrl.mem_read;
  assign MemWrite = ctrl.mem_write;
  assign IRWrite  = ctrl.ir_write;
  assign PCWrite  = ctrl.pc_write;
  assign PCSrc    = ctrl.pc_src;
  assign illegal  = ctrl.illegal;

endmodule

// File: tb/tb_mc_control_fsm.sv
// Bench for mc_control_fsm: each instruction is expanded into its expected
// per-cycle phase/strobe table and compared cycle by cycle.
module tb_mc_control_fsm;

  localparam logic [5:0] PH_IF   = 6'b000001;
  localparam logic [5:0] PH_ID   = 6'b000010;
  localparam logic [5:0] PH_EX   = 6'b000100;
  localparam logic [5:0] PH_MEM  = 6'b001000;
  localparam logic [5:0] PH_WB   = 6'b010000;
  localparam logic [5:0] PH_HALT = 6'b100000;

  localparam logic [5:0] R_OP    = 6'b000000;
  localparam logic [5:0] LW_OP   = 6'b100011;
  localparam logic [5:0] SW_OP   = 6'b101011;
  localparam logic [5:0] BEQ_OP  = 6'b000100;
  localparam logic [5:0] ADDI_OP = 6'b001000;
  localparam logic [5:0] J_OP    = 6'b000010;
  localparam logic [5:0] HALT_OP = 6'b111111;
  localparam logic [5:0] BAD_OP  = 6'b010101;

  logic        clk = 1'b0;
  logic        reset;
  logic [5:0]  opcode;
  logic        zero;
  logic        mem_ready;
  logic [5:0]  state;
  logic [1:0]  ALUop;
  logic        ALUSrc, RegDst, RegWrite, MemtoReg, MemRead, MemWrite;
  logic        IRWrite, PCWrite, illegal;
  logic [1:0]  PCSrc;
  logic [31:0] retired;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;
  logic [31:0] model_ret = 0;

  mc_control_fsm dut (
    .clk(clk), .reset(reset), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
    .state(state), .ALUop(ALUop), .ALUSrc(ALUSrc), .RegDst(RegDst),
    .RegWrite(RegWrite), .MemtoReg(MemtoReg), .MemRead(MemRead),
    .MemWrite(MemWrite), .IRWrite(IRWrite), .PCWrite(PCWrite),
    .PCSrc(PCSrc), .illegal(illegal), .retired(retired)
  );

  always #5 clk = ~clk;

  wire [18:0] obs = {state, ALUop, ALUSrc, RegDst, RegWrite, MemtoReg, MemRead,
                     MemWrite, IRWrite, PCWrite, PCSrc, illegal};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s @%0t: got %h expected %h", tag, $time, got, exp);
  endtask

  function automatic logic [18:0] mk(input logic [5:0] st, input logic [1:0] ao,
                                     input logic as, input logic rd, input logic rw,
                                     input logic m2r, input logic mrd, input logic mwr,
                                     input logic irw, input logic pcw,
                                     input logic [1:0] pcs, input logic ill);
    return {st, ao, as, rd, rw, m2r, mrd, mwr, irw, pcw, pcs, ill};
  endfunction

  function automatic logic [5:0] rnd_op();
    return 6'($urandom());
  endfunction

  function automatic logic rnd_bit();
    return 1'($urandom());
  endfunction

  // One clock of stimulus: drive at the falling edge, compare shortly after.
  task automatic cyc(input logic [5:0] oc, input logic z, input logic mr,
                     input logic [18:0] exp, input string tag);
    @(negedge clk);
    opcode = oc; zero = z; mem_ready = mr;
    #1;
    check(tag, 32'(obs), 32'(exp));
    check({tag, "_ret"}, retired, model_ret);
  endtask

  task automatic run_instr(input logic [5:0] op, input logic z, input int if_wait,
                           input int mem_wait);
    logic is_r, is_lw, is_sw, is_beq, is_addi, is_j, is_halt, legal, has_ex;
    logic [1:0] ao;
    logic as;
    is_r    = (op == R_OP);
    is_lw   = (op == LW_OP);
    is_sw   = (op == SW_OP);
    is_beq  = (op == BEQ_OP);
    is_addi = (op == ADDI_OP);
    is_j    = (op == J_OP);
    is_halt = (op == HALT_OP);
    has_ex  = is_r | is_lw | is_sw | is_beq | is_addi;
    legal   = has_ex | is_j | is_halt;
    ao      = is_r ? 2'b10 : (is_beq ? 2'b01 : 2'b00);
    as      = is_lw | is_sw | is_addi;

    for (int i = 0; i < if_wait; i++)
      cyc(rnd_op(), rnd_bit(), 1'b0, mk(PH_IF, 2'b00, 0, 0, 0, 0, 1, 0, 0, 0, 2'b00, 0), "if_wait");
    cyc(rnd_op(), rnd_bit(), 1'b1, mk(PH_IF, 2'b00, 0, 0, 0, 0, 1, 0, 1, 1, 2'b00, 0), "if_done");
    cyc(op, rnd_bit(), rnd_bit(),
        mk(PH_ID, 2'b00, 0, 0, 0, 0, 0, 0, 0, is_j, is_j ? 2'b10 : 2'b00, ~legal), "id");

    if (has_ex) begin
      cyc(rnd_op(), is_beq ? z : rnd_bit(), rnd_bit(),
          mk(PH_EX, ao, as, 0, 0, 0, 0, 0, 0, is_beq & z, is_beq ? 2'b01 : 2'b00, 0), "ex");
      if (is_lw | is_sw) begin
        for (int i = 0; i < mem_wait; i++)
          cyc(rnd_op(), rnd_bit(), 1'b0,
              mk(PH_MEM, ao, as, 0, 0, 0, is_lw, is_sw, 0, 0, 2'b00, 0), "mem_wait");
        cyc(rnd_op(), rnd_bit(), 1'b1,
            mk(PH_MEM, ao, as, 0, 0, 0, is_lw, is_sw, 0, 0, 2'b00, 0), "mem_done");
      end
      if (is_r | is_addi | is_lw)
        cyc(rnd_op(), rnd_bit(), rnd_bit(),
            mk(PH_WB, ao, as, is_r, 1, is_lw, 0, 0, 0, 0, 2'b00, 0), "wb");
    end

    if (legal && !is_halt) model_ret = model_ret + 32'd1;
    @(posedge clk);
    #1;
    check("retired_end", retired, model_ret);
    check("phase_end", 32'(state), 32'(is_halt ? PH_HALT : PH_IF));
  endtask

  initial begin
    reset = 1'b1; opcode = '0; zero = 1'b0; mem_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_outs", 32'(obs), 32'(mk(PH_IF, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 0)));
    check("reset_ret", retired, 32'd0);
    @(negedge clk);
    reset = 1'b0;

    run_instr(R_OP, 1'b0, 1, 0);
    run_instr(R_OP, 1'b1, 0, 0);
    run_instr(LW_OP, 1'b0, 0, 3);
    run_instr(BEQ_OP, 1'b1, 0, 0);
    run_instr(BEQ_OP, 1'b0, 1, 0);
    run_instr(J_OP, 1'b0, 0, 0);
    run_instr(BAD_OP, 1'b0, 0, 0);
    run_instr(ADDI_OP, 1'b0, 2, 0);
    run_instr(SW_OP, 1'b0, 0, 2);

    // Halt absorbs everything until reset.
    run_instr(HALT_OP, 1'b0, 0, 0);
    for (int i = 0; i < 20; i++)
      cyc(rnd_op(), rnd_bit(), rnd_bit(), mk(PH_HALT, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 0), "halt");
    #1 reset = 1'b1;
    #1;
    check("halt_reset_state", 32'(state), 32'(PH_IF));
    check("halt_reset_ret", retired, 32'd0);
    model_ret = 0;
    @(negedge clk);
    reset = 1'b0; mem_ready = 1'b0;

    // Reset in the middle of a store's EX phase.
    cyc(rnd_op(), rnd_bit(), 1'b1, mk(PH_IF, 2'b00, 0, 0, 0, 0, 1, 0, 1, 1, 2'b00, 0), "sw_if");
    cyc(SW_OP, rnd_bit(), 1'b0, mk(PH_ID, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 0), "sw_id");
    cyc(rnd_op(), rnd_bit(), 1'b1, mk(PH_EX, 2'b00, 1, 0, 0, 0, 0, 0, 0, 0, 2'b00, 0), "sw_ex");
    #1 reset = 1'b1;
    #1;
    check("ex_reset_outs", 32'(obs), 32'(mk(PH_IF, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 0)));
    @(posedge clk);
    #1;
    check("ex_reset_hold", 32'(obs), 32'(mk(PH_IF, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 0)));
    check("ex_reset_ret", retired, 32'd0);
    @(negedge clk);
    reset = 1'b0; mem_ready = 1'b0;
    for (int i = 0; i < 2; i++)
      cyc(rnd_op(), rnd_bit(), 1'b0, mk(PH_IF, 2'b00, 0, 0, 0, 0, 1, 0, 0, 0, 2'b00, 0), "post_reset_if");

    // Randomized instruction stream.
    for (int n = 0; n < 150; n++) begin
      logic [5:0] op;
      int k;
      k = $urandom_range(0, 7);
      case (k)
        0: op = R_OP;
        1: op = LW_OP;
        2: op = SW_OP;
        3: op = BEQ_OP;
        4: op = ADDI_OP;
        5: op = J_OP;
        default: begin
          op = rnd_op();
          if (op == HALT_OP) op = BAD_OP;
        end
      endcase
      run_instr(op, rnd_bit(), $urandom_range(0, 2), $urandom_range(0, 3));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
